// File: rtl/dp_pkg.sv
// Shared datapath constants and operand type for the 16-bit arithmetic pipeline.
package dp_pkg;

  localparam int unsigned DP_WIDTH = 16;
  localparam int unsigned DP_HALF  = DP_WIDTH / 2;

  typedef logic [DP_WIDTH-1:0] dp_word_t;

endpackage : dp_pkg

// File: rtl/add16_pipe_add8.sv
// Combinational ripple adder (Add8) built from single-bit Full_adder cells;
// one instance per pipeline stage.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule : Full_adder

module Add8
  import dp_pkg::*;
#(
  parameter int unsigned WIDTH = DP_HALF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = cin;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    Full_adder u_fa (
      .a    (a[g]),
      .b    (b[g]),
      .cin  (w_c[g]),
      .s    (sum[g]),
      .cout (w_c[g+1])
    );
  end

  assign cout = w_c[WIDTH];

endmodule : Add8

// File: rtl/add16_pipe.sv
// Two-stage pipelined adder: low half in stage 1, high half in stage 2, valid/ready
// on both sides. Define ADD16_OVF_EN to add the registered signed-overflow output ovf.
module add16_pipe
  import dp_pkg::*;
#(
  parameter int unsigned WIDTH = DP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             carry
`ifdef ADD16_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned HALF = WIDTH / 2;

  logic            w_s1_en;
  logic            w_s2_en;
  logic [HALF-1:0] w_lo_sum;
  logic            w_lo_c;
  logic [HALF-1:0] w_hi_sum;
  logic            w_hi_c;

  logic            r_s1_valid;
  logic [HALF-1:0] r_s1_lo;
  logic            r_s1_c8;
  logic [HALF-1:0] r_s1_ahi;
  logic [HALF-1:0] r_s1_bhi;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_o;
  logic             r_carry;

  // No skid buffer: a stalled output propagates straight back to in_ready.
  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  Add8 #(.WIDTH(HALF)) u_add_lo (
    .a    (a[HALF-1:0]),
    .b    (b[HALF-1:0]),
    .cin  (cin),
    .sum  (w_lo_sum),
    .cout (w_lo_c)
  );

  Add8 #(.WIDTH(HALF)) u_add_hi (
    .a    (r_s1_ahi),
    .b    (r_s1_bhi),
    .cin  (r_s1_c8),
    .sum  (w_hi_sum),
    .cout (w_hi_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_c8    <= 1'b0;
      r_s1_ahi   <= '0;
      r_s1_bhi   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      r_s1_lo    <= w_lo_sum;
      r_s1_c8    <= w_lo_c;
      r_s1_ahi   <= a[WIDTH-1:HALF];
      r_s1_bhi   <= b[WIDTH-1:HALF];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_o         <= '0;
      r_carry     <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      r_o         <= {w_hi_sum, r_s1_lo};
      r_carry     <= w_hi_c;
    end
  end

`ifdef ADD16_OVF_EN
  logic r_ovf;

  // Operand sign bits are the MSBs of the high halves already held in stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_s2_en) begin
      r_ovf <= (r_s1_ahi[HALF-1] == r_s1_bhi[HALF-1]) &&
               (w_hi_sum[HALF-1] != r_s1_ahi[HALF-1]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign out_valid = r_out_valid;
  assign o         = r_o;
  assign carry     = r_carry;

endmodule : add16_pipe

// File: tb/tb_add16_pipe.sv
// Self-checking bench for add16_pipe: directed cases plus random streaming,
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_add16_pipe;
  import dp_pkg::*;

  typedef struct {
    logic [16:0] sum;
    logic        ovf;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst;
  logic     in_valid;
  logic     in_ready;
  dp_word_t a;
  dp_word_t b;
  logic     cin;
  logic     out_valid;
  logic     out_ready;
  dp_word_t o;
  logic     carry;
`ifdef ADD16_OVF_EN
  logic     ovf;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_pop    = 0;
  exp_t        q[$];
  logic        accepted;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_out;
  dp_word_t    last_o;

  add16_pipe #(.WIDTH(DP_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .carry     (carry)
`ifdef ADD16_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input dp_word_t x, input dp_word_t y, input logic c);
    exp_t e;
    int   sx, sy, sr;
    e.sum = 17'(x) + 17'(y) + 17'(c);
    sx    = int'($signed(x));
    sy    = int'($signed(y));
    sr    = sx + sy + int'(c);
    e.ovf = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  // One clock: evaluate both handshakes at the falling edge, then advance.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (!rst) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
      if (prev_stall) chk("hold", {15'd0, carry, o}, {15'd0, prev_out});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sum", {15'd0, carry, o}, {15'd0, e.sum});
`ifdef ADD16_OVF_EN
          chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
          n_pop++;
          last_o = o;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {carry, o};
      accepted   = in_valid && in_ready;
      if (accepted) q.push_back(model(a, b, cin));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input dp_word_t x, input dp_word_t y, input logic c);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (accepted) break;
    end
    chk("send_timeout", {31'd0, accepted}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      cycle();
    end
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 16'h1234;
    b         = 16'h4321;
    cin       = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_o", {16'd0, o}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
`ifdef ADD16_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    cycle();
    chk("rst_no_out", {31'd0, out_valid}, 32'd0);

    // Single op with cross-byte carry, plus latency check.
    send(16'h00FF, 16'h0001, 1'b0);
    chk("lat_edge1", {31'd0, out_valid}, 32'd0);
    cycle();
    chk("lat_edge2", {31'd0, out_valid}, 32'd1);
    chk("single_o", {16'd0, o}, 32'h0100);
    chk("single_carry", {31'd0, carry}, 32'd0);
    drain();

    // Wrap-around and maximum operands.
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    drain();

    // Random back-to-back streaming at full rate.
    n_pop    = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a   = dp_word_t'($urandom);
      b   = dp_word_t'($urandom);
      cin = 1'($urandom);
      cycle();
      chk("stream_acc", {31'd0, accepted}, 32'd1);
    end
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("stream_cnt", n_pop, 32'd100);
    drain();

    // Backpressure: fill both stages, hold the third op pending.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h3333, 16'h4444, 1'b0);
    in_valid = 1'b1;
    a        = 16'h5555;
    b        = 16'h1000;
    cin      = 1'b0;
    repeat (5) cycle();
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_o", {16'd0, o}, 32'h3333);
    chk("bp_queued", q.size(), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (accepted) break;
    end
    chk("bp_third_acc", {31'd0, accepted}, 32'd1);
    in_valid = 1'b0;
    drain();
    chk("bp_last", {16'd0, last_o}, 32'h6555);

    // Random stalls interleaved with random input availability.
    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      a         = dp_word_t'($urandom);
      b         = dp_word_t'($urandom);
      cin       = 1'($urandom);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with two ops in flight discards them.
    out_ready = 1'b0;
    send(16'hAAAA, 16'h1111, 1'b0);
    send(16'hBBBB, 16'h2222, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    prev_stall = 1'b0;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (3) cycle();
    send(16'h0001, 16'h0001, 1'b0);
    drain();
    chk("rst_next_o", {16'd0, last_o}, 32'h0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_add16_pipe
